// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Op codes, FSM state constants and small decode helpers.
package muldiv_pkg;

   typedef logic [1:0] op_t;
   typedef logic [1:0] state_t;

   localparam op_t OP_MUL  = 2'b00;
   localparam op_t OP_MULU = 2'b01;
   localparam op_t OP_DIV  = 2'b10;
   localparam op_t OP_DIVU = 2'b11;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   function automatic logic op_is_div(input op_t o);
      return o[1];
   endfunction

   function automatic logic op_signed(input op_t o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the multiply/divide datapath.
// Booth add/sub + arithmetic shift, or restoring trial-subtract + shift.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH+1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             qm1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH+1:0] acc_o,
   output logic [WIDTH-1:0] q_o,
   output logic             qm1_o
);

   localparam int W = WIDTH;

   logic [W+1:0] mx;
   logic [W+1:0] bsum;
   logic [W+1:0] sh;
   logic [W+1:0] trial;

   // Single step: Booth digit from {q[0], q[-1]}, or one restoring quotient bit
   always_comb begin
      mx = {m_i[W], m_i};
      case ({q_i[0], qm1_i})
         2'b01:   bsum = acc_i + mx;
         2'b10:   bsum = acc_i - mx;
         default: bsum = acc_i;
      endcase
      sh    = {acc_i[W:0], q_i[W-1]};
      trial = sh - {1'b0, m_i};
      if (is_div) begin
         qm1_o = 1'b0;
         if (!trial[W+1]) begin
            acc_o = trial;
            q_o   = {q_i[W-2:0], 1'b1};
         end else begin
            acc_o = sh;
            q_o   = {q_i[W-2:0], 1'b0};
         end
      end else begin
         acc_o = {bsum[W+1], bsum[W+1:1]};
         q_o   = {bsum[0], q_i[W-1:1]};
         qm1_o = q_i[0];
      end
   end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed/unsigned MUL/DIV unit for the HI/LO result path.
// FSM IDLE->CALC->FIX->DONE; one iteration per CALC cycle.
module seq_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int W  = WIDTH;
   localparam int CW = cnt_width(WIDTH);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   op_t            op_q, op_d;
   logic [W+1:0]   acc_q, acc_d;
   logic [W-1:0]   q_q, q_d;
   logic           qm1_q, qm1_d;
   logic [W:0]     m_q, m_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           corr_q, corr_d;
   logic           dz_q, dz_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic           done_q, done_d;
   logic           dbz_q, dbz_d;

   logic [W+1:0]   it_acc;
   logic [W-1:0]   it_q;
   logic           it_qm1;

   logic           sgn_in;
   logic [W-1:0]   a_abs;
   logic [W-1:0]   b_abs;
   logic [W-1:0]   quo_n;
   logic [W-1:0]   rem_n;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .is_div (op_is_div(op_q)),
      .acc_i  (acc_q),
      .q_i    (q_q),
      .qm1_i  (qm1_q),
      .m_i    (m_q),
      .acc_o  (it_acc),
      .q_o    (it_q),
      .qm1_o  (it_qm1)
   );

   // Operand magnitudes for division and negated results for sign fix-up
   always_comb begin
      sgn_in = op_signed(op);
      a_abs  = (sgn_in && a[W-1]) ? ('0 - a) : a;
      b_abs  = (sgn_in && b[W-1]) ? ('0 - b) : b;
      quo_n  = '0 - q_q;
      rem_n  = '0 - acc_q[W-1:0];
   end

   // Sequencer: operand load, iteration, fix-up and result publication
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      corr_d  = corr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               op_d   = op;
               cnt_d  = CW'(W - 1);
               acc_d  = '0;
               qm1_d  = 1'b0;
               dz_d   = 1'b0;
               state_d = ST_CALC;
               if (op_is_div(op)) begin
                  m_d    = {1'b0, b_abs};
                  q_d    = a_abs;
                  qneg_d = sgn_in & (a[W-1] ^ b[W-1]);
                  rneg_d = sgn_in & a[W-1];
                  corr_d = 1'b0;
                  if (b == '0) begin
                     // Zero divisor skips the iterations entirely
                     acc_d   = {2'b00, a};
                     q_d     = '1;
                     dz_d    = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  // Multiplicand extended to WIDTH+1 bits by op signedness
                  m_d    = {sgn_in & a[W-1], a};
                  q_d    = b;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
                  corr_d = ~sgn_in & b[W-1];
               end
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = it_acc;
               q_d   = it_q;
               qm1_d = it_qm1;
               if (cnt_q == '0) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_FIX: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               // Unsigned multiplier MSB is the top Booth digit (+M at 2^W)
               if (corr_q) begin
                  acc_d = acc_q + {1'b0, m_q};
               end
               if (qneg_q) begin
                  q_d = quo_n;
               end
               if (rneg_q) begin
                  acc_d = {2'b00, rem_n};
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            hi_d    = acc_q[W-1:0];
            lo_d    = q_q;
            dbz_d   = dz_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; asynchronous clear discards all work
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         corr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         corr_q  <= corr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Self-checking bench for seq_muldiv_unit at WIDTH=32.
// Directed and random ops against a plain-arithmetic reference model.
module tb_seq_muldiv_unit;

   logic        clk;
   logic        clr;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int checks;
   int errors;

   logic [31:0] last_hi;
   logic [31:0] last_lo;
   logic        last_dz;

   seq_muldiv_unit #(
      .WIDTH (32)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
   task automatic model(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] eh,
                        output logic [31:0] el, output logic edz,
                        output int elat);
      longint sx, sy, sq, sr;
      logic [63:0] p;
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      edz  = 1'b0;
      elat = 34;
      case (o)
         2'b00: begin
            p  = 64'(sx * sy);
            eh = p[63:32];
            el = p[31:0];
         end
         2'b01: begin
            p  = {32'b0, x} * {32'b0, y};
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (y == 32'b0) begin
               eh   = x;
               el   = 32'hFFFF_FFFF;
               edz  = 1'b1;
               elat = 1;
            end else if (o == 2'b10) begin
               sq = sx / sy;
               sr = sx % sy;
               el = sq[31:0];
               eh = sr[31:0];
            end else begin
               el = x / y;
               eh = x % y;
            end
         end
      endcase
   endtask

   // Issue one op; optional re-start pulse (rs) or flush (fl) at cycle n
   task automatic run(input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input int rs, input int fl,
                      input string tag);
      logic [31:0] eh, el, dh, dl;
      logic edz, ddz;
      int elat, ndone, dlat;
      model(o, x, y, eh, el, edz, elat);
      @(negedge clk);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      ndone = 0;
      dlat = 0;
      dh = '0;
      dl = '0;
      ddz = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         if (n == rs) begin
            start = 1'b1;
            a = x ^ 32'h0000_5a5a;
         end
         if (n == fl) flush = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         flush = 1'b0;
         a = x;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               dlat = n;
               dh = hi;
               dl = lo;
               ddz = div_by_zero;
            end
         end
         if (n == fl) check({tag, "_flush_busy"}, 64'(busy), 64'd0);
         if (n == 20 && ndone == 0) begin
            check({tag, "_hold_hi"}, 64'(hi), 64'(last_hi));
            check({tag, "_hold_lo"}, 64'(lo), 64'(last_lo));
         end
      end
      if (fl > 0) begin
         check({tag, "_ndone"}, 64'(ndone), 64'd0);
         check({tag, "_keep_hi"}, 64'(hi), 64'(last_hi));
         check({tag, "_keep_lo"}, 64'(lo), 64'(last_lo));
         check({tag, "_keep_dz"}, 64'(div_by_zero), 64'(last_dz));
      end else begin
         check({tag, "_ndone"}, 64'(ndone), 64'd1);
         check({tag, "_lat"}, 64'(dlat), 64'(elat));
         check({tag, "_hi"}, 64'(dh), 64'(eh));
         check({tag, "_lo"}, 64'(dl), 64'(el));
         check({tag, "_dz"}, 64'(ddz), 64'(edz));
         last_hi = eh;
         last_lo = el;
         last_dz = edz;
      end
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      checks  = 0;
      errors  = 0;
      last_hi = '0;
      last_lo = '0;
      last_dz = 1'b0;
      clr   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      clr = 1'b0;

      run(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 0, "mul_7_m3");
      run(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, "mulu_max_2");
      run(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, "mul_m1_2");
      run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_min_m1");
      run(2'b11, 32'd100, 32'd0, 0, 0, "divu_by0");
      run(2'b11, 32'd100, 32'd7, 0, 0, "divu_100_7");
      run(2'b10, 32'd5, 32'd0, 0, 0, "div_by0");
      run(2'b01, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0, "mulu_big");
      run(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0, "div_7_m2");
      run(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0, "mul_restart");
      run(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 10, "mul_flush");
      run(2'b10, 32'hCAFE_0000, 32'd3, 0, 33, "div_flush_fix");

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 5) == 0) ry = 32'd0;
         if ($urandom_range(0, 3) == 0) ry = ry & 32'h0000_00FF;
         run(ro, rx, ry, 0, 0, "rand");
      end

      // start and flush together in IDLE: request dropped
      @(negedge clk);
      op = 2'b00;
      a = 32'd3;
      b = 32'd4;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("idle_flush_busy", 64'(busy), 64'd0);

      // asynchronous clear mid-CALC, after a nonzero divide-by-zero result
      run(2'b11, 32'h0000_0ABC, 32'd0, 0, 0, "pre_clr_dz");
      @(negedge clk);
      op = 2'b00;
      a = 32'h0101_0101;
      b = 32'h0000_0033;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      clr = 1'b1;
      #1;
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_done", 64'(done), 64'd0);
      check("clr_hi", 64'(hi), 64'd0);
      check("clr_lo", 64'(lo), 64'd0);
      check("clr_dz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      clr = 1'b0;
      last_hi = '0;
      last_lo = '0;
      last_dz = 1'b0;
      run(2'b00, 32'hFFFF_FF00, 32'h0000_1234, 0, 0, "post_clr_mul");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
